branch_flush_ctrl: RTL
======================

BRANCH_FLUSH_CTRL -- requirements
Module: branch_flush_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYC, default 0, range 0..15: extra squash cycles after a mispredict.
REQ-002 SHALL have parameter CNT_W, default 16, range 4..32: width of each statistics counter.
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port branch_IF  in  1  decoder: the instruction in IF is a conditional branch.
REQ-006 SHALL have ports icache_stall, dcache_stall, hazard_stall  in  1 each  pipeline stall sources.
REQ-007 SHALL have port bp_correct  in  1  predictor verdict for the branch in ID.
REQ-008 SHALL have port clr_cnt  in  1  synchronous clear of the statistics counters.
REQ-009 SHALL have ports bp_branch_IF, bp_branch_ID, bp_stall  out  1 each  predictor sequencing inputs.
REQ-010 SHALL have ports pc_write_en, if_id_write_en  out  1 each  PC and IF/ID register enables.
REQ-011 SHALL have ports if_id_flush, redirect  out  1 each  squash IF/ID; select the predictor recovery PC.
REQ-012 SHALL have ports br_cnt, mis_cnt  out  CNT_W each  resolved-branch and mispredict counts.
REQ-013 SHALL have port state_o  out  2  FSM state: IDLE=0, WAIT_RES=1, FLUSH=2.

Function
REQ-014 SHALL compute stall = icache_stall | dcache_stall | hazard_stall, then drive bp_stall = stall, pc_write_en = !stall and if_id_write_en = !stall, all combinationally.
REQ-015 SHALL drive bp_branch_ID = 1 only in WAIT_RES.
REQ-016 SHALL drive bp_branch_IF = branch_IF, except force it to 0 in FLUSH and in a mispredict cycle.
REQ-017 IDLE: on branch_IF & !stall, SHALL go to WAIT_RES; otherwise SHALL stay in IDLE.
REQ-018 WAIT_RES with stall=1: SHALL hold state, counters and all flush/redirect outputs at 0.
REQ-019 WAIT_RES, !stall, bp_correct=1 (resolve cycle): SHALL increment br_cnt.
REQ-020 WAIT_RES, !stall, bp_correct=1: next state SHALL be WAIT_RES if branch_IF=1, else IDLE (back-to-back branches supported).
REQ-021 WAIT_RES, !stall, bp_correct=0 (mispredict cycle): SHALL drive redirect=1 and if_id_flush=1 combinationally in that same cycle.
REQ-022 Mispredict cycle: SHALL increment both br_cnt and mis_cnt.
REQ-023 Mispredict cycle: SHALL go to FLUSH and load the squash counter with FLUSH_CYC if FLUSH_CYC>0, else go to IDLE; branch_IF in this cycle SHALL be ignored.
REQ-024 FLUSH: SHALL drive if_id_flush=1 and redirect=0.
REQ-025 FLUSH: SHALL decrement the squash counter only when !stall, and on the unstalled cycle in which it holds 1 SHALL go to IDLE; total squash is exactly FLUSH_CYC unstalled cycles.
REQ-026 Counters SHALL saturate at all-ones and SHALL never wrap.
REQ-027 clr_cnt=1 SHALL zero both counters at the next edge and SHALL take priority over a simultaneous increment; FSM unaffected.
REQ-028 redirect and if_id_flush SHALL never be 1 while stall=1.
REQ-029 The unused state encoding 3 SHALL return to IDLE on the next edge with all outputs inactive.

Reset
REQ-030 With rst_n=0 at an edge, SHALL set state IDLE, squash counter 0, br_cnt=0 and mis_cnt=0, regardless of state (mid-resolution or mid-flush included).
REQ-031 During and after reset, with stall=0 and branch_IF=0, SHALL drive bp_branch_ID=0, redirect=0, if_id_flush=0 and pc_write_en=1.

Verification
REQ-032 Reset: rst_n=0 for 2 cycles from FLUSH -> state_o=0, br_cnt=0, mis_cnt=0, if_id_flush=0, redirect=0.
REQ-033 Correct branch: branch_IF=1 at cycle 1, bp_correct=1 at cycle 2 -> bp_branch_ID=1 at cycle 2, br_cnt=1, mis_cnt=0, no flush, state_o=0 at cycle 3.
REQ-034 Mispredict, FLUSH_CYC=0: bp_correct=0 in WAIT_RES with branch_IF=1 -> same cycle redirect=1, if_id_flush=1, bp_branch_IF=0; mis_cnt=1; state_o=0 next cycle.
REQ-035 Stall in WAIT_RES: dcache_stall=1 for 3 cycles -> state_o=1 held, pc_write_en=0, br_cnt unchanged; resolves on the first unstalled cycle.
REQ-036 FLUSH_CYC=2 mispredict with hazard_stall=1 for 1 cycle inside FLUSH -> if_id_flush=1 on 3 unstalled cycles, state_o=2 for 3 cycles, then 0.
REQ-037 CNT_W=4: 17 resolved branches -> br_cnt=15; clr_cnt=1 together with a resolution -> br_cnt=0 next cycle.

Source files
------------

// File: rtl/branch_flush_ctrl_if.sv
// Signal bundle between the branch flush controller and the pipeline/predictor.
// slave = controller side, master = pipeline/predictor side.
interface branch_flush_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             branch_IF;
  logic             icache_stall;
  logic             dcache_stall;
  logic             hazard_stall;
  logic             bp_correct;
  logic             clr_cnt;
  logic             bp_branch_IF;
  logic             bp_branch_ID;
  logic             bp_stall;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             if_id_flush;
  logic             redirect;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mis_cnt;
  logic [1:0]       state_o;

  modport slave (
    input  branch_IF, icache_stall, dcache_stall, hazard_stall, bp_correct, clr_cnt,
    output bp_branch_IF, bp_branch_ID, bp_stall, pc_write_en, if_id_write_en,
           if_id_flush, redirect, br_cnt, mis_cnt, state_o
  );

  modport master (
    output branch_IF, icache_stall, dcache_stall, hazard_stall, bp_correct, clr_cnt,
    input  bp_branch_IF, bp_branch_ID, bp_stall, pc_write_en, if_id_write_en,
           if_id_flush, redirect, br_cnt, mis_cnt, state_o
  );
endinterface

// File: rtl/branch_flush_ctrl.sv
// Branch resolution / mispredict squash sequencer with saturating branch and
// mispredict statistics counters.
module branch_flush_ctrl #(
  parameter int FLUSH_CYC = 0,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic rst_n,
  branch_flush_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RES = 2'd1,
    FLUSH    = 2'd2,
    UNUSED   = 2'd3
  } state_t;

  localparam logic [3:0]       FC4  = 4'(FLUSH_CYC);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t           r_state, w_next;
  logic [3:0]       r_sq, w_sq_next;
  logic [CNT_W-1:0] r_br, r_mis;
  logic             w_stall, w_resolve, w_mispred;
  logic             w_bid, w_redirect, w_flush, w_kill_bif;

  assign w_stall   = bus.icache_stall | bus.dcache_stall | bus.hazard_stall;
  assign w_resolve = (r_state == WAIT_RES) & ~w_stall;
  assign w_mispred = w_resolve & ~bus.bp_correct;

  always_comb begin
    w_next     = r_state;
    w_sq_next  = r_sq;
    w_bid      = 1'b0;
    w_redirect = 1'b0;
    w_flush    = 1'b0;
    w_kill_bif = 1'b0;
    case (r_state)
      IDLE: if (bus.branch_IF && !w_stall) w_next = WAIT_RES;
      WAIT_RES: begin
        w_bid = 1'b1;
        if (!w_stall) begin
          if (bus.bp_correct) begin
            w_next = bus.branch_IF ? WAIT_RES : IDLE;
          end else begin
            // the branch in IF sits on the wrong path; drop it
            w_redirect = 1'b1;
            w_flush    = 1'b1;
            w_kill_bif = 1'b1;
            if (FC4 != 4'd0) begin
              w_next    = FLUSH;
              w_sq_next = FC4;
            end else begin
              w_next = IDLE;
            end
          end
        end
      end
      FLUSH: begin
        w_kill_bif = 1'b1;
        if (!w_stall) begin
          w_flush = 1'b1;
          if (r_sq <= 4'd1) begin
            w_next    = IDLE;
            w_sq_next = 4'd0;
          end else begin
            w_sq_next = r_sq - 4'd1;
          end
        end
      end
      default: begin
        w_kill_bif = 1'b1;
        w_next     = IDLE;
        w_sq_next  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sq    <= 4'd0;
    end else begin
      r_state <= w_next;
      r_sq    <= w_sq_next;
    end
  end

  // clear beats a same-cycle increment; counters stick at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr_cnt) begin
      r_br  <= '0;
      r_mis <= '0;
    end else begin
      if (w_resolve && r_br != CMAX)  r_br  <= r_br + 1'b1;
      if (w_mispred && r_mis != CMAX) r_mis <= r_mis + 1'b1;
    end
  end

  assign bus.bp_stall       = w_stall;
  assign bus.pc_write_en    = ~w_stall;
  assign bus.if_id_write_en = ~w_stall;
  assign bus.bp_branch_ID   = rst_n & w_bid;
  assign bus.redirect       = rst_n & w_redirect;
  assign bus.if_id_flush    = rst_n & w_flush;
  assign bus.bp_branch_IF   = rst_n & bus.branch_IF & ~w_kill_bif;
  assign bus.br_cnt         = r_br;
  assign bus.mis_cnt        = r_mis;
  assign bus.state_o        = r_state;
endmodule
